// File: rtl/mem_lsu_stage_if.sv
// Data-SRAM request/response bus between the load/store stage and the data SRAM.
// The master side issues req/addr/strobes; the slave side answers with addr_ok,
// data_ok and read data.
interface mem_lsu_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  wr;
    logic [1:0]            size;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_lsu_stage.sv
// Credit-based load/store stage between EX/MEM and MEM/WB.
// Keeps up to OUTST ops in flight or buffered, returns results in issue order,
// raises ALE for misaligned accesses, and discards responses of ops that were
// in flight when an exception flush hit.
module mem_lsu_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OUTST  = 2,
    parameter int SIDE_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               in_we_i,
    input  logic [1:0]         in_size_i,
    input  logic               in_sext_i,
    input  logic [ADDR_W-1:0]  in_addr_i,
    input  logic [DATA_W-1:0]  in_wdata_i,
    input  logic [4:0]         in_rd_i,
    input  logic [SIDE_W-1:0]  in_side_i,
    mem_lsu_stage_if.master    sram,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               out_we_o,
    output logic [4:0]         out_rd_o,
    output logic [DATA_W-1:0]  out_wdata_o,
    output logic               out_excep_o,
    output logic [ADDR_W-1:0]  out_badv_o,
    output logic [SIDE_W-1:0]  out_side_o,
    output logic               busy_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int CW     = $clog2(OUTST + 1);
    localparam int PW     = (OUTST > 1) ? $clog2(OUTST) : 1;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              sext;
        logic [LANE_W-1:0] lane;
        logic [4:0]        rd;
        logic [SIDE_W-1:0] side;
    } pend_t;

    typedef struct packed {
        logic              we;
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
        logic              excep;
        logic [ADDR_W-1:0] badv;
        logic [SIDE_W-1:0] side;
    } res_t;

    pend_t pend_q [OUTST];
    res_t  res_q  [OUTST];

    logic [PW-1:0] pend_head, pend_tail, res_head, res_tail;
    logic [CW-1:0] pend_cnt, res_cnt, cnt, cancel_cnt, cancel_flush;

    logic              credit, misaligned, mis_accept, issue;
    logic              cancel_hit, resp, res_push, res_pop;
    logic [2:0]        align_mask;
    logic [STRB_W-1:0] strb_base;
    logic [DATA_W-1:0] wdata_rep;
    pend_t             pend_in, pend_hd;
    res_t              res_in, res_out;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // Bring the addressed lane down to bit 0, then zero- or sign-extend it.
    function automatic logic [DATA_W-1:0] load_align(
        input logic [DATA_W-1:0] rdata,
        input logic [LANE_W-1:0] lane,
        input logic [1:0]        size,
        input logic              sext
    );
        logic [DATA_W-1:0] sh;
        logic [63:0]       ext;
        sh = rdata >> {lane, 3'b000};
        case (size)
            2'd0:    ext = {{56{sext & sh[7]}},  sh[7:0]};
            2'd1:    ext = {{48{sext & sh[15]}}, sh[15:0]};
            2'd2:    ext = {{32{sext & sh[31]}}, sh[31:0]};
            default: ext = 64'(sh);
        endcase
        return DATA_W'(ext);
    endfunction

    // Alignment check and store lane encoding for the op currently offered.
    always_comb begin
        align_mask = 3'b000;
        strb_base  = '0;
        wdata_rep  = in_wdata_i;
        case (in_size_i)
            2'd0: begin
                align_mask = 3'b000;
                strb_base  = STRB_W'(1);
                wdata_rep  = {(DATA_W/8){in_wdata_i[7:0]}};
            end
            2'd1: begin
                align_mask = 3'b001;
                strb_base  = STRB_W'(3);
                wdata_rep  = {(DATA_W/16){in_wdata_i[15:0]}};
            end
            2'd2: begin
                align_mask = 3'b011;
                strb_base  = STRB_W'(15);
                wdata_rep  = {(DATA_W/32){in_wdata_i[31:0]}};
            end
            default: begin
                align_mask = 3'b111;
                strb_base  = STRB_W'(255);
                wdata_rep  = in_wdata_i;
            end
        endcase
    end

    assign misaligned = |(in_addr_i[2:0] & align_mask);
    assign credit     = (cnt < CW'(OUTST));

    assign sram.req   = in_valid_i & credit & ~flush_i & ~misaligned;
    assign sram.wr    = in_we_i;
    assign sram.size  = in_size_i;
    assign sram.addr  = in_addr_i;
    assign sram.wstrb = in_we_i ? (strb_base << in_addr_i[LANE_W-1:0]) : '0;
    assign sram.wdata = wdata_rep;

    // A misaligned op may only bypass the SRAM once nothing older is still in flight.
    assign in_ready_o = misaligned
                      ? (credit & ~flush_i & (pend_cnt == '0) & (cancel_cnt == '0))
                      : (sram.req & sram.addr_ok);

    assign issue      = sram.req & sram.addr_ok;
    assign mis_accept = in_valid_i & misaligned & in_ready_o;
    assign cancel_hit = sram.data_ok & (cancel_cnt != '0);
    assign resp       = sram.data_ok & (cancel_cnt == '0) & (pend_cnt != '0);
    assign res_push   = resp | mis_accept;
    assign res_pop    = out_ready_i & out_valid_o & ~flush_i;
    assign pend_hd    = pend_q[pend_head];

    // A response arriving in the flush cycle belongs to an op that is being cancelled.
    assign cancel_flush = cancel_cnt + pend_cnt - CW'(cancel_hit | resp);

    // Build the pending and result entries for this cycle's pushes.
    always_comb begin
        pend_in = '{we: in_we_i, size: in_size_i, sext: in_sext_i,
                    lane: in_addr_i[LANE_W-1:0], rd: in_rd_i, side: in_side_i};
        res_in  = '0;
        if (mis_accept) begin
            res_in.rd    = in_rd_i;
            res_in.excep = 1'b1;
            res_in.badv  = in_addr_i;
            res_in.side  = in_side_i;
        end else begin
            res_in.we   = ~pend_hd.we & (pend_hd.rd != 5'd0);
            res_in.rd   = pend_hd.rd;
            res_in.data = pend_hd.we ? '0
                        : load_align(sram.rdata, pend_hd.lane, pend_hd.size, pend_hd.sext);
            res_in.side = pend_hd.side;
        end
    end

    // Occupancy, pointers, credit count and cancel counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_head  <= '0;
            pend_tail  <= '0;
            res_head   <= '0;
            res_tail   <= '0;
            pend_cnt   <= '0;
            res_cnt    <= '0;
            cnt        <= '0;
            cancel_cnt <= '0;
        end else if (flush_i) begin
            pend_head  <= '0;
            pend_tail  <= '0;
            res_head   <= '0;
            res_tail   <= '0;
            pend_cnt   <= '0;
            res_cnt    <= '0;
            cancel_cnt <= cancel_flush;
            cnt        <= cancel_flush;
        end else begin
            if (issue)      pend_tail  <= ptr_inc(pend_tail);
            if (resp)       pend_head  <= ptr_inc(pend_head);
            if (res_push)   res_tail   <= ptr_inc(res_tail);
            if (res_pop)    res_head   <= ptr_inc(res_head);
            if (cancel_hit) cancel_cnt <= cancel_cnt - 1'b1;
            pend_cnt <= pend_cnt + CW'(issue) - CW'(resp);
            res_cnt  <= res_cnt + CW'(res_push) - CW'(res_pop);
            cnt      <= cnt + CW'(issue | mis_accept) - CW'(cancel_hit) - CW'(res_pop);
        end
    end

    // FIFO payload storage; stale slots are never visible because outputs are gated.
    always_ff @(posedge clk) begin
        if (issue)    pend_q[pend_tail] <= pend_in;
        if (res_push) res_q[res_tail]   <= res_in;
    end

    assign out_valid_o = (res_cnt != '0);
    assign res_out     = out_valid_o ? res_q[res_head] : '0;
    assign out_we_o    = res_out.we;
    assign out_rd_o    = res_out.rd;
    assign out_wdata_o = res_out.data;
    assign out_excep_o = res_out.excep;
    assign out_badv_o  = res_out.badv;
    assign out_side_o  = res_out.side;
    assign busy_o      = (cnt != '0);
endmodule
